// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler that shares one UART byte transmitter
// among NUM_REQ requesters. Each byte is sequenced as: issue (send pulse),
// confirm the transmitter started (txdone falls), wait for txdone to rise,
// then an optional inter-byte gap. A per-requester lock holds the grant
// across multi-byte messages.
//
// Handshakes:
//   req/ack   : requester i holds req[i] with its byte on data[8*i+:8]. In IDLE
//               the arbiter takes the winner's byte and pulses ack[i] for one
//               cycle; the requester updates data or drops req in that cycle.
//               req is not re-sampled until the arbiter is back in IDLE.
//   send/txdone: send is a one-cycle start pulse with txdata already valid;
//               the transmitter drops txdone while shifting and raises it when
//               finished. txdata stays stable until the next grant.
module tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDW           = 2,
  parameter int GAP_CLOCKS    = 0,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 tx_err,
  output logic [7:0]           txdata,
  output logic                 send,
  input  logic                 txdone,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = 4;
  localparam int GAP_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2,
    GAP        = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDW-1:0]     last, last_n;
  logic [IDW-1:0]     grant_n;
  logic [7:0]         txdata_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               send_n;
  logic               err_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gap, gap_n;

  logic [IDW-1:0]     win;
  logic [IDW-1:0]     cand;
  logic               found;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Winner selection: a locked last requester keeps the grant, otherwise
  // scan from last+1 upward with wrap so the previous winner goes last.
  always_comb begin : pick_winner
    win   = last;
    cand  = '0;
    found = 1'b0;
    if (lock[last] && req[last]) begin
      win   = last;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDW'((int'(last) + k) % NUM_REQ);
        if (!found && req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Next-state and registered-output logic for the byte sequencer.
  always_comb begin : next_state
    state_n  = state;
    last_n   = last;
    grant_n  = grant_id;
    txdata_n = txdata;
    cnt_n    = cnt;
    gap_n    = gap;
    ack_n    = '0;
    send_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          txdata_n   = data[{win, 3'b000} +: 8];
          ack_n[win] = 1'b1;
          send_n     = 1'b1;
          grant_n    = win;
          last_n     = win;
          cnt_n      = '0;
          state_n    = WAIT_START;
        end
      end
      WAIT_START: begin
        // The byte is already acked; a transmitter that never starts just
        // loses it and raises tx_err.
        if (!txdone) begin
          state_n = WAIT_DONE;
        end else if (cnt == CNT_W'(START_TIMEOUT)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (txdone) begin
          if (GAP_CLOCKS == 0) begin
            state_n = IDLE;
          end else begin
            gap_n   = GAP_W'(GAP_CLOCKS - 1);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gap == '0) begin
          state_n = IDLE;
        end else begin
          gap_n = gap - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clock or posedge reset) begin : regs
    if (reset) begin
      state    <= IDLE;
      last     <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      txdata   <= 8'h00;
      ack      <= '0;
      send     <= 1'b0;
      tx_err   <= 1'b0;
      cnt      <= '0;
      gap      <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant_id <= grant_n;
      txdata   <= txdata_n;
      ack      <= ack_n;
      send     <= send_n;
      tx_err   <= err_n;
      cnt      <= cnt_n;
      gap      <= gap_n;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: one instance with no inter-byte gap for the main
// scenarios and a second with GAP_CLOCKS=5 for gap timing.
module tb_tx_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT A (no gap) ----------------
  logic [3:0]  req  = '0;
  logic [3:0]  lock = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack_a;
  logic [1:0]  grant_a;
  logic        busy_a, err_a, send_a;
  logic [7:0]  txdata_a;
  logic        txdone_a = 1'b1;
  logic [1:0]  dbg_a;

  tx_arbiter #(.NUM_REQ(4), .IDW(2), .GAP_CLOCKS(0), .START_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock), .data(data),
    .ack(ack_a), .grant_id(grant_a), .busy(busy_a), .tx_err(err_a),
    .txdata(txdata_a), .send(send_a), .txdone(txdone_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B (gap of 5) ----------------
  logic [3:0]  req_b  = '0;
  logic [3:0]  lock_b = '0;
  logic [31:0] data_b = '0;
  logic [3:0]  ack_b;
  logic [1:0]  grant_b;
  logic        busy_b, err_b, send_b;
  logic [7:0]  txdata_b;
  logic        txdone_b = 1'b1;
  logic [1:0]  dbg_b;

  tx_arbiter #(.NUM_REQ(4), .IDW(2), .GAP_CLOCKS(5), .START_TIMEOUT(15)) dut_gap (
    .clock(clock), .reset(reset), .req(req_b), .lock(lock_b), .data(data_b),
    .ack(ack_b), .grant_id(grant_b), .busy(busy_b), .tx_err(err_b),
    .txdata(txdata_b), .send(send_b), .txdone(txdone_b), .dbg_state(dbg_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- transmitter models ----------------
  int   frame_len = 10;
  logic tie_a     = 1'b0;
  int   cnt_ma    = 0;
  int   cnt_mb    = 0;

  always @(posedge clock) begin
    #2;
    if (reset || tie_a) begin
      txdone_a = 1'b1;
      cnt_ma   = 0;
    end else if (send_a) begin
      txdone_a = 1'b0;
      cnt_ma   = frame_len;
    end else if (cnt_ma > 0) begin
      cnt_ma--;
      if (cnt_ma == 0) txdone_a = 1'b1;
    end
  end

  always @(posedge clock) begin
    #2;
    if (reset) begin
      txdone_b = 1'b1;
      cnt_mb   = 0;
    end else if (send_b) begin
      txdone_b = 1'b0;
      cnt_mb   = 10;
    end else if (cnt_mb > 0) begin
      cnt_mb--;
      if (cnt_mb == 0) txdone_b = 1'b1;
    end
  end

  // ---------------- scoreboard (DUT A) ----------------
  logic [9:0] exp_q[$];   // {grant id, byte}
  logic [9:0] e;
  logic       prev_send = 1'b0;

  function automatic logic [7:0] byte_of(input int i, input int n);
    return 8'((i * 64 + n * 13 + 21) & 255);
  endfunction

  task automatic push(input int id, input int n);
    exp_q.push_back({id[1:0], byte_of(id, n)});
  endtask

  always @(posedge clock) begin
    #1;
    if (reset) begin
      prev_send = 1'b0;
    end else begin
      if (prev_send) check("pulse_len", {send_a, ack_a}, 0);
      if (!send_a && ack_a != 4'b0000) check("ack_without_send", ack_a, 0);
      if (send_a) begin
        if (exp_q.size() == 0) begin
          check("unexpected_send", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("grant_id", grant_a, e[9:8]);
          check("txdata", txdata_a, e[7:0]);
          check("ack", ack_a, 4'b0001 << e[9:8]);
        end
      end
      prev_send = send_a;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_a && t < 2000) begin
      @(posedge clock); #1;
      t++;
    end
    check("idle_timeout", t < 2000, 1);
  endtask

  // Drive up to four requesters; each drops req after its last byte is acked.
  task automatic run_burst(input logic [3:0] lockv, input int c0, input int c1,
                           input int c2, input int c3, input int lock_acks);
    int left[4];
    int sent[4];
    int acks   = 0;
    int budget = 0;
    left = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      sent[i]       = 0;
      data[8*i +: 8] = byte_of(i, 0);
      req[i]        = (left[i] > 0);
    end
    lock = lockv;
    while ((left[0] + left[1] + left[2] + left[3]) > 0 && budget < 3000) begin
      @(posedge clock); #1;
      budget++;
      for (int i = 0; i < 4; i++) begin
        if (ack_a[i] && left[i] > 0) begin
          left[i]--;
          sent[i]++;
          data[8*i +: 8] = byte_of(i, sent[i]);
          if (left[i] == 0) req[i] = 1'b0;
          acks++;
          if (acks == lock_acks) lock = '0;
        end
      end
    end
    check("burst_timeout", budget < 3000, 1);
    req = '0;
    wait_idle();
  endtask

  // ---------------- tests ----------------
  initial begin
    int t;

    // Reset values
    do_reset();
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_send", send_a, 0);
    check("rst_ack", ack_a, 0);
    check("rst_err", err_a, 0);
    check("rst_txdata", txdata_a, 8'h00);
    check("rst_grant", grant_a, 0);

    // 1. Single byte from requester 2, 100-clock frame
    frame_len = 100;
    exp_q.push_back({2'd2, 8'hA5});
    data[23:16] = 8'hA5;
    req = 4'b0100;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (ack_a == 4'b0000 && t < 20);
    check("single_latency", t, 1);
    req = 4'b0000;
    t = 0;
    do begin
      @(posedge clock); #3;
      t++;
    end while (!txdone_a && t < 300);
    check("single_frame_end", t < 300, 1);
    check("single_busy_in_frame", busy_a, 1);
    @(posedge clock); #1;
    check("single_busy_after", busy_a, 0);
    frame_len = 10;

    // 2. Round robin, all four requesting, two bytes each
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(i, r);
    run_burst(4'b0000, 2, 2, 2, 2, 0);

    // 3. Lock holds requester 0 for three bytes, then rotation resumes
    do_reset();
    push(0, 0); push(0, 1); push(0, 2); push(1, 0); push(0, 3);
    run_burst(4'b0001, 4, 1, 0, 0, 3);

    // 4. Transmitter never starts: tx_err 16 clocks after send
    do_reset();
    tie_a = 1'b1;
    push(0, 0);
    data[7:0] = byte_of(0, 0);
    req = 4'b0001;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!send_a && t < 20);
    req = 4'b0000;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!err_a && t < 40);
    check("timeout_delay", t, 16);
    check("timeout_idle", busy_a, 0);
    @(posedge clock); #1;
    check("timeout_err_pulse", err_a, 0);
    tie_a = 1'b0;

    // 5. Gap of 5 between back-to-back bytes on the second instance
    data_b[7:0] = 8'h3C;
    req_b = 4'b0001;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!send_b && t < 20);
    check("gap_first_byte", txdata_b, 8'h3C);
    data_b[7:0] = 8'hC3;
    t = 0;
    do begin
      @(posedge clock); #3;
      t++;
    end while (!txdone_b && t < 100);
    @(posedge clock);   // edge that samples txdone high
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!send_b && t < 50);
    check("gap_spacing", t, 6);
    check("gap_second_byte", txdata_b, 8'hC3);
    check("gap_second_ack", ack_b, 4'b0001);
    req_b = 4'b0000;

    // 6. Reset in the middle of a frame, then a fresh arbitration
    do_reset();
    frame_len = 20;
    push(2, 0);
    data[23:16] = byte_of(2, 0);
    req = 4'b0100;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (ack_a == 4'b0000 && t < 20);
    req = 4'b0000;
    repeat (5) @(posedge clock);
    #3;
    check("mid_frame_state", dbg_a, 2'd2);
    reset = 1'b1;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_send", send_a, 0);
    check("abort_ack", ack_a, 0);
    check("abort_err", err_a, 0);
    check("abort_txdata", txdata_a, 8'h00);
    check("abort_grant", grant_a, 0);
    @(negedge clock);
    reset = 1'b0;
    frame_len = 10;
    push(0, 0); push(3, 0);
    run_burst(4'b0000, 1, 0, 0, 1, 0);

    repeat (3) @(posedge clock);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
